pwm_ramp_controller: RTL and testbench

//   Slew-rate controller between the SPI register bank and pwm_peripheral.

---
 rtl/pwm_ramp_controller.sv | 146 ++++++++++++++
 tb/tb_pwm_ramp_controller.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_controller.sv
// -----------------------------------------------------------------------------
// pwm_ramp_controller
//   Slew-rate limiter placed between the SPI register bank and pwm_peripheral.
//   The SPI-written target duty is approached in steps of step_size, one step
//   every step_div+1 clock cycles, so software writes never make the PWM jump.
//
//   Optional feature macro: PWM_RAMP_LIMIT_EN
//     defined   -> extra input duty_limit; the effective target becomes
//                  min(target_duty, duty_limit), and a live duty above the
//                  limit is ramped down to it at the normal rate.
//     undefined -> effective target is target_duty.
// -----------------------------------------------------------------------------
module pwm_ramp_controller #(
    parameter int DUTY_W  = 8,
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [DUTY_W-1:0]  target_duty,
    input  logic [PRESC_W-1:0] step_div,
    input  logic [DUTY_W-1:0]  step_size,
`ifdef PWM_RAMP_LIMIT_EN
    input  logic [DUTY_W-1:0]  duty_limit,
`endif
    output logic [DUTY_W-1:0]  duty_out,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2,
        HOLD      = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [DUTY_W-1:0]    duty_q, duty_d;
    logic [PRESC_W-1:0]   cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [DUTY_W-1:0]    eff_target;
    logic [DUTY_W-1:0]    step_eff;
    logic [DUTY_W:0]      up_sum;
    logic [DUTY_W-1:0]    up_val;
    logic [DUTY_W-1:0]    dn_gap;
    logic [DUTY_W-1:0]    dn_val;
    logic                 in_ramp;
    logic                 tick;

    // Effective target: the SPI target, optionally clipped by the duty limit.
`ifdef PWM_RAMP_LIMIT_EN
    always_comb begin
        eff_target = (duty_limit < target_duty) ? duty_limit : target_duty;
    end
`else
    always_comb begin
        eff_target = target_duty;
    end
`endif

    // Step datapath: saturating up/down candidates that can never pass the target.
    always_comb begin
        step_eff = (step_size == '0) ? DUTY_W'(1) : step_size;
        // One extra bit so duty+step near full scale clamps instead of wrapping.
        up_sum   = {1'b0, duty_q} + {1'b0, step_eff};
        up_val   = (up_sum >= {1'b0, eff_target}) ? eff_target : up_sum[DUTY_W-1:0];
        // Only meaningful when duty_q > eff_target; gap <= step means we land.
        dn_gap   = duty_q - eff_target;
        dn_val   = (dn_gap <= step_eff) ? eff_target : (duty_q - step_eff);
        in_ramp  = (state_q == RAMP_UP) || (state_q == RAMP_DOWN);
        tick     = in_ramp && (cnt_q >= step_div);
    end

    // Next-state logic: direction is re-evaluated against the live target every cycle.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        duty_d  = duty_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        if (!en) begin
            state_d = IDLE;
            duty_d  = '0;
            cnt_d   = '0;
        end else begin
            if (tick) begin
                if (duty_q < eff_target) begin
                    duty_d = up_val;
                end else if (duty_q > eff_target) begin
                    duty_d = dn_val;
                end
            end

            // Prescaler runs only while ramping; outside a ramp it sits at zero,
            // so entry from IDLE/HOLD always starts a fresh step interval.
            if (in_ramp) begin
                cnt_d = tick ? '0 : (cnt_q + PRESC_W'(1));
            end else begin
                cnt_d = '0;
            end

            if (tick && (duty_q != eff_target) && (duty_d == eff_target)) begin
                done_d  = 1'b1;
                state_d = HOLD;
            end else if (duty_d < eff_target) begin
                state_d = RAMP_UP;
            end else if (duty_d > eff_target) begin
                state_d = RAMP_DOWN;
            end else begin
                state_d = HOLD;
            end

            busy_d = (state_d == RAMP_UP) || (state_d == RAMP_DOWN);
        end
    end

    // State and registered outputs; async reset returns everything to idle at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            duty_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q <= state_d;
            duty_q  <= duty_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign duty_out = duty_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// -----------------------------------------------------------------------------
// tb_pwm_ramp_controller
//   Directed scenarios followed by randomized stimulus, every cycle compared
//   against a behavioural model of the slew-rate rules.
//   Define PWM_RAMP_LIMIT_EN to exercise the duty_limit variant.
// -----------------------------------------------------------------------------
module tb_pwm_ramp_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] target_duty;
    logic [7:0] step_div;
    logic [7:0] step_size;
    logic [7:0] duty_limit;
    logic [7:0] duty_out;
    logic       busy;
    logic       done;

    int n_vec  = 0;
    int n_fail = 0;

    // Behavioural model state
    int m_duty;
    int m_cnt;
    bit m_ramp;
    bit m_done;
    int n_done_seen;

    always #5 clk = ~clk;

    pwm_ramp_controller #(.DUTY_W(8), .PRESC_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .target_duty (target_duty),
        .step_div    (step_div),
        .step_size   (step_size),
`ifdef PWM_RAMP_LIMIT_EN
        .duty_limit  (duty_limit),
`endif
        .duty_out    (duty_out),
        .busy        (busy),
        .done        (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int eff_tgt();
        int t;
        t = int'(target_duty);
`ifdef PWM_RAMP_LIMIT_EN
        if (int'(duty_limit) < t) t = int'(duty_limit);
`endif
        return t;
    endfunction

    task automatic model_reset();
        m_duty = 0;
        m_cnt  = 0;
        m_ramp = 0;
        m_done = 0;
    endtask

    // One clock edge of the reference behaviour, using the inputs held over the edge.
    task automatic model_edge();
        int tgt;
        int stp;
        tgt = eff_tgt();
        stp = (step_size == 8'd0) ? 1 : int'(step_size);
        if (!en) begin
            model_reset();
        end else begin
            m_done = 0;
            if (m_ramp && m_cnt >= int'(step_div)) begin
                m_cnt = 0;
                if (m_duty < tgt) begin
                    m_duty = (m_duty + stp > tgt) ? tgt : m_duty + stp;
                    m_done = (m_duty == tgt);
                end else if (m_duty > tgt) begin
                    m_duty = (m_duty - stp < tgt) ? tgt : m_duty - stp;
                    m_done = (m_duty == tgt);
                end
            end else if (m_ramp) begin
                m_cnt++;
            end else begin
                m_cnt = 0;
            end
            m_ramp = m_done ? 1'b0 : (m_duty != tgt);
        end
    endtask

    // Advance one cycle: model follows the edge, outputs checked on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("duty", duty_out, m_duty);
        check("busy", busy, m_ramp);
        check("done", done, m_done);
        if (done) n_done_seen++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int changes;
        int last_chg;
        int prev;
        int peak;
        bit reached;

        rst_n       = 1'b0;
        en          = 1'b0;
        target_duty = 8'h00;
        step_div    = 8'h00;
        step_size   = 8'h00;
        duty_limit  = 8'hFF;
        model_reset();

        #12;
        check("rst_duty", duty_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Scenario 1: fast ramp 0 -> 0x40 in steps of 0x10
        en = 1'b1; target_duty = 8'h40; step_div = 8'd0; step_size = 8'h10;
        n_done_seen = 0;
        repeat (8) cycle();
        check("s1_final", duty_out, 8'h40);
        check("s1_busy_after", busy, 0);
        check("s1_done_count", n_done_seen, 1);

        // Scenario 2: step_div=3, step=1, 0 -> 3, one change every 4th cycle
        en = 1'b0; cycle();
        en = 1'b1; target_duty = 8'd3; step_div = 8'd3; step_size = 8'd1;
        n_done_seen = 0; changes = 0; last_chg = -1; prev = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (int'(duty_out) != prev) begin
                if (last_chg >= 0) check("s2_spacing", i - last_chg, 4);
                changes++;
                last_chg = i;
                prev = int'(duty_out);
            end
        end
        check("s2_changes", changes, 3);
        check("s2_done_count", n_done_seen, 1);

        // Scenario 3: no wrap near full scale, no underflow near zero
        en = 1'b0; cycle();
        en = 1'b1; target_duty = 8'hF8; step_div = 8'd0; step_size = 8'h10;
        repeat (24) cycle();
        check("s3_at_f8", duty_out, 8'hF8);
        target_duty = 8'hFF; n_done_seen = 0;
        repeat (4) cycle();
        check("s3_at_ff", duty_out, 8'hFF);
        check("s3_done_ff", n_done_seen, 1);
        target_duty = 8'h05;
        repeat (24) cycle();
        check("s3_at_05", duty_out, 8'h05);

        // Scenario 4: reverse mid-ramp without overshooting the new target
        en = 1'b0; cycle();
        en = 1'b1; target_duty = 8'h80; step_div = 8'd0; step_size = 8'h08;
        reached = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            cycle();
            if (duty_out == 8'h30) reached = 1'b1;
        end
        check("s4_reach_30", reached, 1);
        target_duty = 8'h20; peak = 0; n_done_seen = 0;
        repeat (6) begin
            cycle();
            if (int'(duty_out) > peak) peak = int'(duty_out);
        end
        check("s4_peak", peak, 8'h28);
        check("s4_final", duty_out, 8'h20);
        check("s4_done_count", n_done_seen, 1);

        // Scenario 5: en dropped mid-ramp
        en = 1'b0; cycle();
        en = 1'b1; target_duty = 8'hF0; step_div = 8'd2; step_size = 8'd1;
        repeat (10) cycle();
        en = 1'b0;
        cycle();
        check("s5_duty_zero", duty_out, 0);
        check("s5_busy_zero", busy, 0);

        // Scenario 6: asynchronous reset mid-ramp, no clock edge needed
        en = 1'b1; target_duty = 8'hF0; step_div = 8'd1; step_size = 8'd4;
        repeat (8) cycle();
        #2 rst_n = 1'b0;
        #1;
        check("s6_async_duty", duty_out, 0);
        check("s6_async_busy", busy, 0);
        check("s6_async_done", done, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) cycle();

        // Scenario 7: step_size 0 behaves as 1
        en = 1'b0; cycle();
        en = 1'b1; target_duty = 8'd5; step_div = 8'd0; step_size = 8'd0;
        repeat (8) cycle();
        check("s7_final", duty_out, 8'd5);

        // Scenario 8: lowering step_div is seen on the next cycle
        target_duty = 8'hFF; step_div = 8'd200; step_size = 8'd1;
        repeat (5) cycle();
        step_div = 8'd0;
        cycle();
        check("s8_live_div", duty_out, 8'd6);

`ifdef PWM_RAMP_LIMIT_EN
        // Scenario 9: duty limit clips the target and pulls duty down
        en = 1'b0; cycle();
        en = 1'b1; duty_limit = 8'h50; target_duty = 8'hC0; step_div = 8'd0; step_size = 8'h08;
        repeat (16) cycle();
        check("s9_at_limit", duty_out, 8'h50);
        duty_limit = 8'h30;
        repeat (8) cycle();
        check("s9_lowered", duty_out, 8'h30);
        duty_limit = 8'hFF;
`endif

        // Randomized stimulus
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 39) == 0) en = ~en;
            else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
            if ($urandom_range(0, 14) == 0) target_duty = 8'($urandom);
            if ($urandom_range(0, 29) == 0) step_div = 8'($urandom_range(0, 4));
            if ($urandom_range(0, 19) == 0) step_size = 8'($urandom_range(0, 48));
`ifdef PWM_RAMP_LIMIT_EN
            if ($urandom_range(0, 29) == 0) duty_limit = 8'($urandom);
`endif
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
